alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 clock  in  1  single system clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 start  in  1  request pulse; accepted only when busy=0.
REQ-004 op_mode  in  5  ALU mode code, latched at accept.
REQ-005 op_dst / op_src  in  5 each  destination / source register index, latched at accept.
REQ-006 op_imm  in  8; op_use_imm  in  1  immediate operand; 1 = use op_imm instead of Rr.
REQ-007 busy  out  1  high from cycle after accept through done cycle inclusive.
REQ-008 done  out  1  one-cycle pulse in final cycle of an operation.
REQ-009 rf_addr  out  5  register-file read address; rf_rdata  in  8, valid one cycle after rf_addr.
REQ-010 rf_we  out  1; rf_waddr  out  5; rf_wdata  out  8  single 8-bit register-file write port.
REQ-011 alu_mode  out  5; alu_d, alu_r, alu_s  out  8; alu_op1w  out  16  ALU operands, all driven from internal registers.
REQ-012 alu_R, alu_S  in  8; alu_resw  in  16  combinational ALU results.
REQ-013 sreg  out  8  internal status register, fed back as alu_s.

Function
REQ-014 Mode classes:
- LDI: 0.
- R2W (Rd op Rr/imm, write Rd): 2, 3, 6, 7, 8, 9, 10.
- CMP (no write): 1, 5.
- ONE (Rd only, alu_r=op_imm, write Rd): 12-19, 22.
- SRG: 11.
- WIDE: 20, 21; alu_r=op_imm; operands Rd+1:Rd.
- MUL: 23-25; result to R1:R0.
- INV: 4, 26-31.
REQ-015 States: IDLE, RD_D, RD_S, RD_H, CAP, EXEC, WR_LO, WR_HI.
REQ-016 RD_D drives rf_addr=dst; RD_S drives rf_addr=src and latches d; RD_H drives rf_addr=dst+1 (5-bit wrap, 31->0) and latches op1w low byte; CAP latches the last operand read.
REQ-017 Sequences, with cycle 0 = accept cycle:
- R2W/CMP/SRG register form: RD_D, RD_S, CAP, EXEC.
- With op_use_imm=1 (R2W/CMP): RD_D, CAP, EXEC.
- ONE: RD_D, CAP, EXEC.
- WIDE: RD_D, RD_H, CAP, EXEC.
- MUL: RD_D, RD_S, CAP, EXEC.
- LDI, SRG with op_use_imm=1, INV: EXEC only; for LDI alu_d=0x00, alu_r=op_imm.
REQ-018 EXEC: alu_mode=latched mode; at clock edge sreg<=alu_S for all non-INV modes; result register <= alu_R (8-bit classes) or alu_resw (WIDE/MUL).
REQ-019 After EXEC:
- R2W/ONE/LDI -> WR_LO (waddr=dst, wdata=result).
- WIDE -> WR_LO (dst, resw[7:0]), then WR_HI (dst+1, resw[15:8]).
- MUL -> WR_LO (R0, low byte), then WR_HI (R1, high byte).
- CMP/SRG/INV -> IDLE; done asserted in EXEC.
REQ-020 rf_we=1 only in WR_LO/WR_HI; done asserted in the last write state.
REQ-021 Latency, accept to done:
- R2W register form 5; R2W imm / ONE 4; CMP register form 4, imm 3.
- WIDE 6; MUL 6; LDI 2.
- SRG register form 4, imm 1; INV 1.
REQ-022 start while busy=1, including the done cycle, is ignored with no effect.
REQ-023 INV: no rf write, sreg unchanged, done pulses.
REQ-024 No read and write in the same cycle; an operation accepted after done reads the values written by the previous operation.

Reset
REQ-025 Reset forces, on the next edge, state=IDLE and all outputs to zero: busy, done, rf_we, rf_addr, rf_waddr, rf_wdata, alu_mode, alu_d, alu_r, alu_op1w, sreg.
REQ-026 Reset mid-operation abandons the operation: no further rf_we, no done; start is accepted the cycle after reset deasserts.

Verification
REQ-027 ADD (mode 3), r5=0x7F, r6=0x01, sreg=0x00 -> WR_LO at cycle 5 writes r5=0x80, done cycle 5, sreg=0x2C.
REQ-028 ADIW (mode 20), dst=24, r24=0xFF, r25=0x00, imm=0x01 -> r24<=0x00 at cycle 5, r25<=0x01 at cycle 6, done cycle 6, sreg=0x00.
REQ-029 MUL (mode 23), r16=0x10, r17=0x20 -> r0<=0x00 at cycle 5, r1<=0x02 at cycle 6, done cycle 6, sreg=0x00.
REQ-030 CP (mode 5), r2=r3=0x42 -> rf_we never asserted, done cycle 4, sreg=0x02.
REQ-031 LDI dst=20, imm=0xA5 with a second start at cycle 1 -> r20<=0xA5 at cycle 2, sreg unchanged, second start ignored.
REQ-032 Reset at cycle 3 of the ADD from REQ-027 -> no write, no done, busy=0 and sreg=0x00 next cycle; a re-issued ADD then completes per REQ-027.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Command, register-file and ALU bus between the ALU sequencer (slave side)
// and its environment (master side: command source, register file, ALU).
interface alu_sequencer_if;
    logic        start;
    logic [4:0]  op_mode;
    logic [4:0]  op_dst;
    logic [4:0]  op_src;
    logic [7:0]  op_imm;
    logic        op_use_imm;
    logic        busy;
    logic        done;

    logic [4:0]  rf_addr;
    logic [7:0]  rf_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [7:0]  rf_wdata;

    logic [4:0]  alu_mode;
    logic [7:0]  alu_d;
    logic [7:0]  alu_r;
    logic [7:0]  alu_s;
    logic [15:0] alu_op1w;
    logic [7:0]  alu_R;
    logic [7:0]  alu_S;
    logic [15:0] alu_resw;
    logic [7:0]  sreg;

    modport master (
        output start, op_mode, op_dst, op_src, op_imm, op_use_imm,
        output rf_rdata, alu_R, alu_S, alu_resw,
        input  busy, done, rf_addr, rf_we, rf_waddr, rf_wdata,
        input  alu_mode, alu_d, alu_r, alu_s, alu_op1w, sreg
    );

    modport slave (
        input  start, op_mode, op_dst, op_src, op_imm, op_use_imm,
        input  rf_rdata, alu_R, alu_S, alu_resw,
        output busy, done, rf_addr, rf_we, rf_waddr, rf_wdata,
        output alu_mode, alu_d, alu_r, alu_s, alu_op1w, sreg
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: fetches operands from an 8-bit register file, drives
// an external combinational ALU, then writes back one or two result bytes.
module alu_sequencer (
    input  logic            clock,
    input  logic            reset,
    alu_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, RD_D, RD_S, RD_H, CAP, EXEC, WR_LO, WR_HI
    } state_t;

    typedef enum logic [2:0] {
        C_LDI, C_R2W, C_CMP, C_ONE, C_SRG, C_WIDE, C_MUL, C_INV
    } op_class_t;

    function automatic op_class_t decode(input logic [4:0] m);
        op_class_t c;
        c = C_INV;
        case (m)
            5'd0:                                  c = C_LDI;
            5'd2, 5'd3, 5'd6, 5'd7, 5'd8, 5'd9,
            5'd10:                                 c = C_R2W;
            5'd1, 5'd5:                            c = C_CMP;
            5'd12, 5'd13, 5'd14, 5'd15, 5'd16,
            5'd17, 5'd18, 5'd19, 5'd22:            c = C_ONE;
            5'd11:                                 c = C_SRG;
            5'd20, 5'd21:                          c = C_WIDE;
            5'd23, 5'd24, 5'd25:                   c = C_MUL;
            default:                               c = C_INV;
        endcase
        return c;
    endfunction

    state_t     state;
    op_class_t  cls;
    logic [4:0] mode_q;
    logic [4:0] dst_q;
    logic [4:0] src_q;
    logic [7:0] imm_q;
    logic       use_imm_q;
    logic [7:0] res_hi;

    logic        busy_q;
    logic        done_q;
    logic [4:0]  rf_addr_q;
    logic        rf_we_q;
    logic [4:0]  rf_waddr_q;
    logic [7:0]  rf_wdata_q;
    logic [4:0]  alu_mode_q;
    logic [7:0]  alu_d_q;
    logic [7:0]  alu_r_q;
    logic [15:0] alu_op1w_q;
    logic [7:0]  sreg_q;

    op_class_t start_cls;
    logic      start_exec_only;
    logic      reads_src;
    logic      no_write;
    logic      two_writes;

    assign start_cls       = decode(bus.op_mode);
    // Operations with no register operand skip the read states entirely.
    assign start_exec_only = (start_cls == C_LDI) || (start_cls == C_INV) ||
                             ((start_cls == C_SRG) && bus.op_use_imm);

    assign reads_src  = (cls == C_MUL) ||
                        (!use_imm_q && ((cls == C_R2W) || (cls == C_CMP) || (cls == C_SRG)));
    assign no_write   = (cls == C_CMP) || (cls == C_SRG) || (cls == C_INV);
    assign two_writes = (cls == C_WIDE) || (cls == C_MUL);

    // NOTE: every register below is assigned with <= so each branch sees the
    // pre-edge values of all others, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cls        <= C_LDI;
            mode_q     <= '0;
            dst_q      <= '0;
            src_q      <= '0;
            imm_q      <= '0;
            use_imm_q  <= 1'b0;
            res_hi     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rf_addr_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            alu_mode_q <= '0;
            alu_d_q    <= '0;
            alu_r_q    <= '0;
            alu_op1w_q <= '0;
            sreg_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cls       <= start_cls;
                        mode_q    <= bus.op_mode;
                        dst_q     <= bus.op_dst;
                        src_q     <= bus.op_src;
                        imm_q     <= bus.op_imm;
                        use_imm_q <= bus.op_use_imm;
                        busy_q    <= 1'b1;
                        if (start_exec_only) begin
                            state      <= EXEC;
                            alu_mode_q <= bus.op_mode;
                            alu_d_q    <= 8'h00;
                            alu_r_q    <= bus.op_imm;
                            done_q     <= (start_cls != C_LDI);
                        end else begin
                            state     <= RD_D;
                            rf_addr_q <= bus.op_dst;
                        end
                    end
                end

                RD_D: begin
                    if (cls == C_WIDE) begin
                        state     <= RD_H;
                        rf_addr_q <= dst_q + 5'd1;
                    end else if (reads_src) begin
                        state     <= RD_S;
                        rf_addr_q <= src_q;
                    end else begin
                        state <= CAP;
                    end
                end

                RD_S: begin
                    alu_d_q <= bus.rf_rdata;
                    state   <= CAP;
                end

                RD_H: begin
                    alu_d_q          <= bus.rf_rdata;
                    alu_op1w_q[7:0]  <= bus.rf_rdata;
                    state            <= CAP;
                end

                CAP: begin
                    // rf_rdata now holds the last address issued: Rd+1, Rr or Rd.
                    if (cls == C_WIDE) begin
                        alu_op1w_q[15:8] <= bus.rf_rdata;
                        alu_r_q          <= imm_q;
                    end else if (reads_src) begin
                        alu_r_q <= bus.rf_rdata;
                    end else begin
                        alu_d_q <= bus.rf_rdata;
                        alu_r_q <= imm_q;
                    end
                    alu_mode_q <= mode_q;
                    done_q     <= no_write;
                    state      <= EXEC;
                end

                EXEC: begin
                    if (cls != C_INV) begin
                        sreg_q <= bus.alu_S;
                    end
                    res_hi <= bus.alu_resw[15:8];
                    if (no_write) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end else begin
                        state      <= WR_LO;
                        rf_we_q    <= 1'b1;
                        rf_waddr_q <= (cls == C_MUL) ? 5'd0 : dst_q;
                        rf_wdata_q <= two_writes ? bus.alu_resw[7:0] : bus.alu_R;
                        done_q     <= !two_writes;
                    end
                end

                WR_LO: begin
                    if (two_writes) begin
                        state      <= WR_HI;
                        rf_waddr_q <= (cls == C_MUL) ? 5'd1 : dst_q + 5'd1;
                        rf_wdata_q <= res_hi;
                        done_q     <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        rf_we_q <= 1'b0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end

                WR_HI: begin
                    state   <= IDLE;
                    rf_we_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rf_addr  = rf_addr_q;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.alu_mode = alu_mode_q;
    assign bus.alu_d    = alu_d_q;
    assign bus.alu_r    = alu_r_q;
    assign bus.alu_op1w = alu_op1w_q;
    assign bus.alu_s    = sreg_q;
    assign bus.sreg     = sreg_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: register file and ALU stub around the sequencer, with a
// per-operation reference model for latency, writes, done/busy and sreg.
module tb_alu_sequencer;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Register file: registered read, one write port, plus a bench preload port.
    logic [7:0] mem [32];
    logic       pl_we;
    logic [4:0] pl_addr;
    logic [7:0] pl_data;

    always @(posedge clock) begin
        bus.rf_rdata <= mem[bus.rf_addr];
        if (bus.rf_we) mem[bus.rf_waddr] <= bus.rf_wdata;
        if (pl_we) mem[pl_addr] <= pl_data;
    end

    // AVR-flavoured ALU: {R, S, resw}; flags C=0 Z=1 N=2 V=3 S=4 H=5.
    function automatic logic [31:0] alu_fn(input logic [4:0] m, input logic [7:0] d,
                                           input logic [7:0] r, input logic [7:0] s,
                                           input logic [15:0] w);
        logic [8:0]  sum;
        logic [7:0]  res;
        logic [15:0] rw;
        logic [7:0]  fl;
        logic        h, v, n, z, c;
        sum = '0; res = '0; rw = '0; fl = s;
        h = 1'b0; v = 1'b0; n = 1'b0; z = 1'b0; c = 1'b0;
        case (m)
            5'd0: res = r;
            5'd3: begin
                sum = {1'b0, d} + {1'b0, r};
                res = sum[7:0];
                c = sum[8]; n = res[7]; z = (res == 8'h00);
                h = (d[3] & r[3]) | (r[3] & ~res[3]) | (~res[3] & d[3]);
                v = (d[7] & r[7] & ~res[7]) | (~d[7] & ~r[7] & res[7]);
                fl = {s[7:6], h, n ^ v, v, n, z, c};
            end
            5'd1, 5'd5: begin
                sum = {1'b0, d} - {1'b0, r};
                res = sum[7:0];
                c = sum[8]; n = res[7]; z = (res == 8'h00);
                h = (~d[3] & r[3]) | (r[3] & res[3]) | (res[3] & ~d[3]);
                v = (d[7] & ~r[7] & ~res[7]) | (~d[7] & r[7] & res[7]);
                fl = {s[7:6], h, n ^ v, v, n, z, c};
            end
            5'd20, 5'd21: begin
                rw = (m == 5'd20) ? w + {8'h00, r} : w - {8'h00, r};
                res = rw[7:0];
                n = rw[15]; z = (rw == 16'h0000);
                v = (m == 5'd20) ? (~w[15] & rw[15]) : (w[15] & ~rw[15]);
                c = (m == 5'd20) ? (~rw[15] & w[15]) : (rw[15] & ~w[15]);
                fl = {s[7:6], 1'b0, n ^ v, v, n, z, c};
            end
            5'd23, 5'd24, 5'd25: begin
                rw = {8'h00, d} * {8'h00, r};
                res = rw[7:0];
                fl = {s[7:6], 4'b0000, rw == 16'h0000, rw[15]};
            end
            5'd4, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31: begin
                res = d + r;
                fl = ~s;
            end
            default: begin
                res = (d ^ {3'b000, m}) + r;
                rw = {res, d ^ r};
                fl = s + res + {3'b000, m};
            end
        endcase
        return {res, fl, rw};
    endfunction

    logic [31:0] alu_out;
    always_comb alu_out = alu_fn(bus.alu_mode, bus.alu_d, bus.alu_r, bus.alu_s, bus.alu_op1w);
    assign bus.alu_R    = alu_out[31:24];
    assign bus.alu_S    = alu_out[23:16];
    assign bus.alu_resw = alu_out[15:0];

    // Reference model state.
    typedef enum {K_LDI, K_R2W, K_CMP, K_ONE, K_SRG, K_WIDE, K_MUL, K_INV} kind_t;
    logic [7:0] ref_rf [32];
    logic [7:0] ref_sreg;

    function automatic kind_t kind_of(input int m);
        if (m == 0) return K_LDI;
        if (m inside {2, 3, 6, 7, 8, 9, 10}) return K_R2W;
        if (m inside {1, 5}) return K_CMP;
        if (m inside {[12:19], 22}) return K_ONE;
        if (m == 11) return K_SRG;
        if (m inside {20, 21}) return K_WIDE;
        if (m inside {[23:25]}) return K_MUL;
        return K_INV;
    endfunction

    task automatic drive_junk(input logic st);
        bus.start      = st;
        bus.op_mode    = 5'($urandom_range(31));
        bus.op_dst     = 5'($urandom_range(31));
        bus.op_src     = 5'($urandom_range(31));
        bus.op_imm     = 8'($urandom_range(255));
        bus.op_use_imm = 1'($urandom_range(1));
    endtask

    task automatic set_reg(input logic [4:0] a, input logic [7:0] v);
        pl_we = 1'b1; pl_addr = a; pl_data = v;
        @(negedge clock);
        pl_we = 1'b0;
        ref_rf[a] = v;
    endtask

    // Issues one operation at the current negedge (cycle 0) and checks every
    // cycle up to the first idle cycle. noise: 0 quiet, 1 random, 2 always start.
    task automatic run_op(input logic [4:0] m, input logic [4:0] dst, input logic [4:0] src,
                          input logic [7:0] imm, input logic use_imm, input int noise);
        kind_t       k;
        int          lat, nw, wi;
        logic [4:0]  hi;
        logic [7:0]  d, r, exp_sreg;
        logic [15:0] w;
        logic [31:0] a;
        logic [4:0]  wa [2];
        logic [7:0]  wd [2];
        int          wc [2];

        k  = kind_of(int'(m));
        hi = dst + 5'd1;
        d  = ref_rf[dst];
        r  = use_imm ? imm : ref_rf[src];
        w  = {ref_rf[hi], ref_rf[dst]};
        case (k)
            K_LDI:  begin lat = 2; d = 8'h00; r = imm; end
            K_R2W:  lat = use_imm ? 4 : 5;
            K_CMP:  lat = use_imm ? 3 : 4;
            K_ONE:  begin lat = 4; r = imm; end
            K_SRG:  if (use_imm) begin lat = 1; d = 8'h00; r = imm; end
                    else begin lat = 4; r = ref_rf[src]; end
            K_WIDE: begin lat = 6; r = imm; end
            K_MUL:  begin lat = 6; r = ref_rf[src]; end
            default: begin lat = 1; d = 8'h00; r = imm; end
        endcase
        a = alu_fn(m, d, r, ref_sreg, w);
        exp_sreg = (k == K_INV) ? ref_sreg : a[23:16];

        nw = 0;
        wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0; wc[0] = 0; wc[1] = 0;
        if (k inside {K_LDI, K_R2W, K_ONE}) begin
            wa[0] = dst; wd[0] = a[31:24]; wc[0] = lat; nw = 1;
        end else if (k == K_WIDE) begin
            wa[0] = dst; wd[0] = a[7:0];  wc[0] = lat - 1;
            wa[1] = hi;  wd[1] = a[15:8]; wc[1] = lat; nw = 2;
        end else if (k == K_MUL) begin
            wa[0] = 5'd0; wd[0] = a[7:0];  wc[0] = lat - 1;
            wa[1] = 5'd1; wd[1] = a[15:8]; wc[1] = lat; nw = 2;
        end

        bus.start = 1'b1; bus.op_mode = m; bus.op_dst = dst; bus.op_src = src;
        bus.op_imm = imm; bus.op_use_imm = use_imm;
        wi = 0;
        for (int cyc = 1; cyc <= lat + 1; cyc++) begin
            @(negedge clock);
            check($sformatf("m%0d_busy_c%0d", m, cyc), 32'(bus.busy), 32'(cyc <= lat));
            check($sformatf("m%0d_done_c%0d", m, cyc), 32'(bus.done), 32'(cyc == lat));
            if (wi < nw && wc[wi] == cyc) begin
                check($sformatf("m%0d_we_c%0d", m, cyc), 32'(bus.rf_we), 32'd1);
                check($sformatf("m%0d_waddr_c%0d", m, cyc), 32'(bus.rf_waddr), 32'(wa[wi]));
                check($sformatf("m%0d_wdata_c%0d", m, cyc), 32'(bus.rf_wdata), 32'(wd[wi]));
                wi++;
            end else begin
                check($sformatf("m%0d_we_c%0d", m, cyc), 32'(bus.rf_we), 32'd0);
            end
            if (cyc <= lat && (noise == 2 || (noise == 1 && $urandom_range(1) == 1)))
                drive_junk(1'b1);
            else
                drive_junk(1'b0);
        end
        check($sformatf("m%0d_sreg", m), 32'(bus.sreg), 32'(exp_sreg));
        for (int i = 0; i < nw; i++) ref_rf[wa[i]] = wd[i];
        ref_sreg = exp_sreg;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        drive_junk(1'b0);
        ref_sreg = 8'h00;
        repeat (2) @(negedge clock);

        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_rf_we",    32'(bus.rf_we),    32'd0);
        check("rst_rf_addr",  32'(bus.rf_addr),  32'd0);
        check("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        check("rst_rf_wdata", 32'(bus.rf_wdata), 32'd0);
        check("rst_alu_mode", 32'(bus.alu_mode), 32'd0);
        check("rst_alu_d",    32'(bus.alu_d),    32'd0);
        check("rst_alu_r",    32'(bus.alu_r),    32'd0);
        check("rst_alu_op1w", 32'(bus.alu_op1w), 32'd0);
        check("rst_sreg",     32'(bus.sreg),     32'd0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) set_reg(5'(i), 8'($urandom_range(255)));

        // ADD r5,r6
        set_reg(5'd5, 8'h7F); set_reg(5'd6, 8'h01);
        run_op(5'd3, 5'd5, 5'd6, 8'h00, 1'b0, 0);
        check("add_r5",   32'(mem[5]),   32'h80);
        check("add_sreg", 32'(bus.sreg), 32'h2C);

        // ADIW r25:r24,1
        set_reg(5'd24, 8'hFF); set_reg(5'd25, 8'h00);
        run_op(5'd20, 5'd24, 5'd0, 8'h01, 1'b1, 0);
        check("adiw_r24",  32'(mem[24]),  32'h00);
        check("adiw_r25",  32'(mem[25]),  32'h01);
        check("adiw_sreg", 32'(bus.sreg), 32'h00);

        // MUL r16,r17
        set_reg(5'd16, 8'h10); set_reg(5'd17, 8'h20);
        run_op(5'd23, 5'd16, 5'd17, 8'h00, 1'b0, 0);
        check("mul_r0",   32'(mem[0]),   32'h00);
        check("mul_r1",   32'(mem[1]),   32'h02);
        check("mul_sreg", 32'(bus.sreg), 32'h00);

        // CP r2,r3
        set_reg(5'd2, 8'h42); set_reg(5'd3, 8'h42);
        run_op(5'd5, 5'd2, 5'd3, 8'h00, 1'b0, 0);
        check("cp_sreg", 32'(bus.sreg), 32'h02);

        // LDI r20 with start held high while busy
        run_op(5'd0, 5'd20, 5'd0, 8'hA5, 1'b0, 2);
        check("ldi_r20",  32'(mem[20]),  32'hA5);
        check("ldi_sreg", 32'(bus.sreg), 32'h02);

        // Reset during cycle 3 of an ADD, then re-issue on the next cycle
        set_reg(5'd5, 8'h7F);
        bus.start = 1'b1; bus.op_mode = 5'd3; bus.op_dst = 5'd5; bus.op_src = 5'd6;
        bus.op_imm = 8'h00; bus.op_use_imm = 1'b0;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clock);
            drive_junk(1'b0);
            check($sformatf("rst_add_busy_c%0d", cyc), 32'(bus.busy), 32'd1);
            if (cyc == 3) reset = 1'b1;
        end
        @(negedge clock);
        check("rst_add_busy",  32'(bus.busy),  32'd0);
        check("rst_add_done",  32'(bus.done),  32'd0);
        check("rst_add_we",    32'(bus.rf_we), 32'd0);
        check("rst_add_sreg",  32'(bus.sreg),  32'd0);
        reset = 1'b0;
        ref_sreg = 8'h00;
        run_op(5'd3, 5'd5, 5'd6, 8'h00, 1'b0, 0);
        check("readd_r5",   32'(mem[5]),   32'h80);
        check("readd_sreg", 32'(bus.sreg), 32'h2C);

        // Randomized operations, back-to-back or with idle gaps
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(3) == 0) @(negedge clock);
            run_op(5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)),
                   8'($urandom_range(255)), 1'($urandom_range(1)), int'($urandom_range(1)));
        end

        for (int i = 0; i < 32; i++)
            check($sformatf("final_r%0d", i), 32'(mem[i]), 32'(ref_rf[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
